// File: rtl/jtkicker_rom_arb.sv
// jtkicker_rom_arb: two-requester single-entry ROM cache sharing one SDRAM slot, with timeout retry.
module jtkicker_rom_arb #(
  parameter int          AW      = 14,
  parameter int          DW      = 32,
  parameter logic [7:0]  TIMEOUT = 8'd255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          obj_cs,
  input  logic [AW-1:0] obj_addr,
  output logic          obj_ok,
  output logic [DW-1:0] obj_data,
  input  logic          scr_cs,
  input  logic [AW-1:0] scr_addr,
  output logic          scr_ok,
  output logic [DW-1:0] scr_data,
  output logic          sd_cs,
  output logic [AW-1:0] sd_addr,
  input  logic          sd_ok,
  input  logic [DW-1:0] sd_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  state_t st, st_nxt;
  logic [AW-1:0] obj_tag, scr_tag;
  logic [7:0] cnt;
  logic obj_valid, scr_valid, prio, gnt;
  logic obj_pend, scr_pend, pick_scr, tout, grant, done, fill;
  assign obj_ok   = obj_cs & obj_valid & (obj_addr == obj_tag);
  assign scr_ok   = scr_cs & scr_valid & (scr_addr == scr_tag);
  assign obj_pend = obj_cs & ~obj_ok;
  assign scr_pend = scr_cs & ~scr_ok;
  assign pick_scr = scr_pend & (~obj_pend | prio);
  assign tout     = cnt == TIMEOUT;
  assign grant    = st == IDLE && (obj_pend || scr_pend);
  assign fill     = st == ISSUE && sd_ok;
  assign done     = st == ISSUE && (sd_ok || tout);
  always_comb begin
    st_nxt = st == IDLE ? (grant ? ISSUE : IDLE) : st == ISSUE ? (done ? GAP : ISSUE) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_cs     <= 1'b0;
      sd_addr   <= '0;
      prio      <= 1'b0;
      gnt       <= 1'b0;
      cnt       <= '0;
      obj_tag   <= '0;
      scr_tag   <= '0;
      obj_data  <= '0;
      scr_data  <= '0;
      obj_valid <= 1'b0;
      scr_valid <= 1'b0;
    end else begin
      if (grant) begin
        gnt     <= pick_scr;
        sd_addr <= pick_scr ? scr_addr : obj_addr;
        sd_cs   <= 1'b1;
        cnt     <= '0;
      end
      if (st == ISSUE) cnt <= tout ? cnt : cnt + 8'd1;
      if (done) sd_cs <= 1'b0;
      if (fill) prio <= ~gnt;
      if (fill && !gnt) begin
        obj_tag   <= sd_addr;
        obj_data  <= sd_data;
        obj_valid <= 1'b1;
      end
      if (fill && gnt) begin
        scr_tag   <= sd_addr;
        scr_data  <= sd_data;
        scr_valid <= 1'b1;
      end
      // flush wins over a coincident fill so stale data is never marked valid
      if (flush) begin
        obj_valid <= 1'b0;
        scr_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_jtkicker_rom_arb.sv
// tb_jtkicker_rom_arb: directed checks of hits, misses, arbitration, flush, reset and timeout.
module tb_jtkicker_rom_arb;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic obj_cs = 1'b0, scr_cs = 1'b0, sd_ok = 1'b0;
  logic [13:0] obj_addr = '0, scr_addr = '0;
  logic [31:0] sd_data = '0;
  logic obj_ok, scr_ok, sd_cs;
  logic [31:0] obj_data, scr_data;
  logic [13:0] sd_addr;
  logic t_obj_ok, t_scr_ok, t_sd_cs;
  logic [31:0] t_obj_data, t_scr_data;
  logic [13:0] t_sd_addr;
  int n = 0, fails = 0;

  always #5 clk = ~clk;

  jtkicker_rom_arb dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_ok(obj_ok), .obj_data(obj_data),
    .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_ok(scr_ok), .scr_data(scr_data),
    .sd_cs(sd_cs), .sd_addr(sd_addr), .sd_ok(sd_ok), .sd_data(sd_data)
  );

  jtkicker_rom_arb #(.TIMEOUT(8'd4)) dut_t (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_ok(t_obj_ok), .obj_data(t_obj_data),
    .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_ok(t_scr_ok), .scr_data(t_scr_data),
    .sd_cs(t_sd_cs), .sd_addr(t_sd_addr), .sd_ok(sd_ok), .sd_data(sd_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cs(input string tag);
    int k = 0;
    while (!sd_cs && k < 8) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, sd_cs}, 32'd1);
  endtask

  task automatic pulse_ok(input logic [31:0] d);
    sd_ok = 1'b1;
    sd_data = d;
    tick();
    sd_ok = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_sd_cs", {31'd0, sd_cs}, 32'd0);
    chk("rst_sd_addr", {18'd0, sd_addr}, 32'd0);
    chk("rst_ok", {30'd0, obj_ok, scr_ok}, 32'd0);
    chk("rst_obj_data", obj_data, 32'd0);
    chk("rst_scr_data", scr_data, 32'd0);
    rst_n = 1'b1;
    tick();
    // single miss, sd_ok five cycles after sd_cs
    obj_cs = 1'b1;
    obj_addr = 14'h0123;
    tick();
    chk("miss_sd_cs", {31'd0, sd_cs}, 32'd1);
    chk("miss_sd_addr", {18'd0, sd_addr}, 32'h0123);
    chk("miss_obj_ok0", {31'd0, obj_ok}, 32'd0);
    repeat (4) tick();
    chk("miss_hold_cs", {31'd0, sd_cs}, 32'd1);
    pulse_ok(32'hDEADBEEF);
    chk("miss_obj_ok", {31'd0, obj_ok}, 32'd1);
    chk("miss_obj_data", obj_data, 32'hDEADBEEF);
    chk("miss_cs_drop", {31'd0, sd_cs}, 32'd0);
    // hit: no further SDRAM traffic
    tick();
    tick();
    chk("hit_obj_ok", {31'd0, obj_ok}, 32'd1);
    chk("hit_sd_cs", {31'd0, sd_cs}, 32'd0);
    // contention from reset
    rst_n = 1'b0;
    #1;
    chk("rst2_obj_ok", {31'd0, obj_ok}, 32'd0);
    tick();
    obj_addr = 14'h0010;
    scr_cs = 1'b1;
    scr_addr = 14'h0020;
    rst_n = 1'b1;
    tick();
    chk("cont_first_obj", {18'd0, sd_addr}, 32'h0010);
    pulse_ok(32'h11111111);
    chk("cont_obj_data", obj_data, 32'h11111111);
    chk("cont_obj_ok", {31'd0, obj_ok}, 32'd1);
    chk("cont_scr_ok0", {31'd0, scr_ok}, 32'd0);
    tick();
    chk("cont_gap_cs", {31'd0, sd_cs}, 32'd0);
    wait_cs("cont_scr_cs");
    chk("cont_then_scr", {18'd0, sd_addr}, 32'h0020);
    pulse_ok(32'h22222222);
    chk("cont_scr_data", scr_data, 32'h22222222);
    chk("cont_scr_ok", {31'd0, scr_ok}, 32'd1);
    obj_addr = 14'h0030;
    scr_addr = 14'h0040;
    wait_cs("alt1_cs");
    chk("alt1_obj", {18'd0, sd_addr}, 32'h0030);
    pulse_ok(32'h33333333);
    obj_addr = 14'h0050;
    wait_cs("alt2_cs");
    chk("alt2_scr", {18'd0, sd_addr}, 32'h0040);
    pulse_ok(32'h44444444);
    chk("alt2_scr_data", scr_data, 32'h44444444);
    wait_cs("alt3_cs");
    chk("alt3_obj", {18'd0, sd_addr}, 32'h0050);
    pulse_ok(32'h55555555);
    chk("alt3_obj_ok", {31'd0, obj_ok}, 32'd1);
    // address changes while the request is in flight
    scr_cs = 1'b0;
    obj_addr = 14'h0070;
    wait_cs("chg_cs");
    obj_addr = 14'h0071;
    pulse_ok(32'h77777777);
    chk("chg_new_miss", {31'd0, obj_ok}, 32'd0);
    obj_addr = 14'h0070;
    #1;
    chk("chg_old_hit", {31'd0, obj_ok}, 32'd1);
    chk("chg_old_data", obj_data, 32'h77777777);
    // flush coincident with sd_ok
    tick();
    tick();
    obj_addr = 14'h0060;
    wait_cs("fl_cs");
    flush = 1'b1;
    pulse_ok(32'h66666666);
    flush = 1'b0;
    chk("fl_obj_ok", {31'd0, obj_ok}, 32'd0);
    chk("fl_cs_drop", {31'd0, sd_cs}, 32'd0);
    wait_cs("fl_reissue_cs");
    chk("fl_reissue_addr", {18'd0, sd_addr}, 32'h0060);
    pulse_ok(32'h66666667);
    chk("fl_refill", obj_data, 32'h66666667);
    chk("fl_refill_ok", {31'd0, obj_ok}, 32'd1);
    // reset during ISSUE
    obj_addr = 14'h0080;
    wait_cs("rmid_cs");
    rst_n = 1'b0;
    #1;
    chk("rmid_cs_drop", {31'd0, sd_cs}, 32'd0);
    chk("rmid_ok", {30'd0, obj_ok, scr_ok}, 32'd0);
    chk("rmid_data", obj_data, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rmid_restart_cs", {31'd0, sd_cs}, 32'd1);
    chk("rmid_restart_addr", {18'd0, sd_addr}, 32'h0080);
    // timeout with TIMEOUT=4 and no sd_ok
    obj_cs = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    scr_cs = 1'b1;
    scr_addr = 14'h0100;
    tick();
    chk("to_cs_start", {31'd0, t_sd_cs}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("to_cs_hold%0d", i), {31'd0, t_sd_cs}, 32'd1);
    end
    tick();
    chk("to_cs_drop", {31'd0, t_sd_cs}, 32'd0);
    chk("to_scr_ok", {31'd0, t_scr_ok}, 32'd0);
    begin
      int k = 0;
      while (!t_sd_cs && k < 4) begin
        tick();
        k++;
      end
    end
    chk("to_reissue_cs", {31'd0, t_sd_cs}, 32'd1);
    chk("to_reissue_addr", {18'd0, t_sd_addr}, 32'h0100);
    chk("to_cache_clean", t_scr_data | t_obj_data, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
